uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm_if.sv | 28 ++
 rtl/uart_rx_fsm.sv | 114 +++++++++++
 tb/tb_uart_rx_fsm.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Control/result bundle between the UART receive FSM and its edge counter,
// sampler, deserializer and start/parity/stop checkers.
interface uart_rx_fsm_if #(
    parameter int Prescale_width = 6
);
    // Strobes are one-cycle pulses from the FSM (no backpressure); each checker
    // result must be valid on the cycle after its strobe and is sampled at bit end.
    logic [Prescale_width-1:0] edge_cnt;
    logic                      edge_cnt_en;
    logic                      dat_samp_en;
    logic                      deser_en;
    logic                      strt_chk_en;
    logic                      par_chk_en;
    logic                      stp_chk_en;
    logic                      strt_glitch;
    logic                      par_err;
    logic                      stp_err;

    modport master (
        output edge_cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
        input  edge_cnt, strt_glitch, par_err, stp_err
    );

    modport slave (
        input  edge_cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
        output edge_cnt, strt_glitch, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: walks START/DATA/PARITY/STOP using an external
// edge counter and reports one registered status pulse per completed frame.
module uart_rx_fsm #(
    parameter int Prescale_width = 6,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      RX_IN,
    input  logic [Prescale_width-1:0] Prescale,
    input  logic                      PAR_EN,
    uart_rx_fsm_if.master             ctl,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      framing_error,
    output logic [2:0]                state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0]                LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic [Prescale_width-1:0] ONE      = Prescale_width'(1);
    localparam logic [Prescale_width-1:0] TWO      = Prescale_width'(2);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] bit_cnt;
    logic       par_flag;
    logic       par_en_q;
    logic       bit_end;
    logic       at_check;
    logic       enter_start;
    logic       frame_end;

    assign bit_end   = (ctl.edge_cnt == (Prescale - ONE));
    assign at_check  = (ctl.edge_cnt == (Prescale - TWO));
    assign state_dbg = state;

    always_comb begin
        state_nxt       = state;
        enter_start     = 1'b0;
        frame_end       = 1'b0;
        ctl.strt_chk_en = 1'b0;
        ctl.deser_en    = 1'b0;
        ctl.par_chk_en  = 1'b0;
        ctl.stp_chk_en  = 1'b0;
        ctl.edge_cnt_en = (state != IDLE);
        ctl.dat_samp_en = (state != IDLE);
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt   = START;
                    enter_start = 1'b1;
                end
            end
            START: begin
                ctl.strt_chk_en = at_check;
                if (bit_end) state_nxt = ctl.strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                ctl.deser_en = at_check;
                if (bit_end && (bit_cnt == LAST_BIT)) state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                ctl.par_chk_en = at_check;
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                ctl.stp_chk_en = at_check;
                if (bit_end) begin
                    frame_end = 1'b1;
                    // A low line at stop-bit end is the next frame's start bit.
                    if (!RX_IN) begin
                        state_nxt   = START;
                        enter_start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bit_cnt       <= 4'd0;
            par_flag      <= 1'b0;
            par_en_q      <= 1'b0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_nxt;
            data_valid    <= frame_end && !ctl.stp_err && !par_flag;
            parity_error  <= frame_end && !ctl.stp_err && par_flag;
            framing_error <= frame_end && ctl.stp_err;
            if (enter_start) begin
                bit_cnt  <= 4'd0;
                par_flag <= 1'b0;
                par_en_q <= PAR_EN;
            end else begin
                if ((state == DATA) && bit_end) bit_cnt <= bit_cnt + 4'd1;
                if ((state == PARITY) && bit_end) par_flag <= par_flag | ctl.par_err;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm with a modelled edge counter and checker results;
// status pulses are queued by a monitor and matched against expected codes.
module tb_uart_rx_fsm;
    logic       clk;
    logic       reset_n;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int deser_cnt = 0;
    int deser_bad = 0;
    int par_chk_cnt = 0;

    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    int         obs_cyc_q[$];
    int         start_q[$];

    uart_rx_fsm_if #(.Prescale_width(6)) bus ();

    uart_rx_fsm #(.Prescale_width(6), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .ctl          (bus),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External edge counter: held at 0 while disabled, wraps at Prescale-1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.edge_cnt <= 6'd0;
        else if (!bus.edge_cnt_en) bus.edge_cnt <= 6'd0;
        else if (bus.edge_cnt >= Prescale - 6'd1) bus.edge_cnt <= 6'd0;
        else bus.edge_cnt <= bus.edge_cnt + 6'd1;
    end

    always @(negedge clk) begin
        if (bus.deser_en) begin
            deser_cnt++;
            if (bus.edge_cnt != 6'd6) deser_bad++;
        end
        if (bus.par_chk_en) par_chk_cnt++;
        if (state_dbg == 3'd1 && bus.edge_cnt == 6'd0) start_q.push_back(cyc);
        if (data_valid || parity_error || framing_error) begin
            obs_q.push_back({framing_error, parity_error, data_valid});
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        start_q.delete();
        deser_cnt   = 0;
        deser_bad   = 0;
        par_chk_cnt = 0;
    endtask

    // Called on a negedge; returns on a negedge. b2b drops the line for the
    // next start bit during the final stop-bit cycle.
    task automatic send_frame(input logic [7:0] d, input bit with_par, input bit b2b);
        RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (8) @(negedge clk);
        end
        if (with_par) begin
            RX_IN = ^d;
            repeat (8) @(negedge clk);
        end
        RX_IN = 1'b1;
        repeat (b2b ? 7 : 8) @(negedge clk);
    endtask

    task automatic test_reset();
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        Prescale = 6'd8;
        bus.strt_glitch = 1'b0;
        bus.par_err = 1'b0;
        bus.stp_err = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", state_dbg);
        end
        checks++;
        if ({bus.edge_cnt_en, bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
             bus.par_chk_en, bus.stp_chk_en} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got nonzero strobe outputs, want 0");
        end
        checks++;
        if ({framing_error, parity_error, data_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_status: got %b want 000",
                               {framing_error, parity_error, data_valid});
        end
        reset_n = 1'b1;
        clear_sb();
        repeat (6) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || state_dbg !== 3'd0) begin
            errors++; $display("FAIL idle_after_reset: got %0d pulses state %0d want 0 pulses state 0",
                               obs_q.size(), state_dbg);
        end
    endtask

    task automatic test_frame_55();
        clear_sb();
        exp_q.push_back(3'b001);
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (deser_cnt != 8 || deser_bad != 0) begin
            errors++; $display("FAIL f55_deser: got %0d pulses (%0d off-point) want 8 (0)",
                               deser_cnt, deser_bad);
        end
        checks++;
        if (par_chk_cnt != 0) begin
            errors++; $display("FAIL f55_par_chk: got %0d want 0", par_chk_cnt);
        end
        checks++;
        if (obs_q.size() != 1 || start_q.size() != 1) begin
            errors++; $display("FAIL f55_count: got %0d pulses %0d starts want 1 1",
                               obs_q.size(), start_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++; $display("FAIL f55_code: got %b want %b", obs_q[0], exp_q[0]);
            end
            checks++;
            if (obs_cyc_q[0] - start_q[0] != 80) begin
                errors++; $display("FAIL f55_latency: got %0d want 80", obs_cyc_q[0] - start_q[0]);
            end
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL f55_idle: got %0d want 0", state_dbg);
        end
    endtask

    task automatic test_start_glitch();
        clear_sb();
        bus.strt_glitch = 1'b1;
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (state_dbg !== 3'd1) begin
            errors++; $display("FAIL glitch_still_start: got %0d want 1", state_dbg);
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL glitch_back_idle: got %0d want 0", state_dbg);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (deser_cnt != 0 || obs_q.size() != 0) begin
            errors++; $display("FAIL glitch_quiet: got %0d deser %0d pulses want 0 0",
                               deser_cnt, obs_q.size());
        end
        bus.strt_glitch = 1'b0;
    endtask

    task automatic test_parity_error();
        clear_sb();
        PAR_EN = 1'b1;
        bus.par_err = 1'b1;
        exp_q.push_back(3'b010);
        fork
            send_frame(8'hA3, 1'b1, 1'b0);
            begin
                repeat (4) @(negedge clk);
                PAR_EN = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        checks++;
        if (par_chk_cnt != 1) begin
            errors++; $display("FAIL par_chk_count: got %0d want 1", par_chk_cnt);
        end
        checks++;
        if (obs_q.size() != 1 || start_q.size() != 1) begin
            errors++; $display("FAIL par_count: got %0d pulses %0d starts want 1 1",
                               obs_q.size(), start_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++; $display("FAIL par_code: got %b want %b", obs_q[0], exp_q[0]);
            end
            checks++;
            if (obs_cyc_q[0] - start_q[0] != 88) begin
                errors++; $display("FAIL par_latency: got %0d want 88", obs_cyc_q[0] - start_q[0]);
            end
        end
        bus.par_err = 1'b0;
    endtask

    task automatic test_framing_error();
        clear_sb();
        PAR_EN = 1'b1;
        bus.par_err = 1'b1;
        bus.stp_err = 1'b1;
        exp_q.push_back(3'b100);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL frm_count: got %0d want 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++; $display("FAIL frm_code: got %b want %b", obs_q[0], exp_q[0]);
            end
        end
        PAR_EN = 1'b0;
        bus.par_err = 1'b0;
        bus.stp_err = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0;
        logic [7:0] d1;
        clear_sb();
        d0 = 8'($urandom_range(0, 255));
        d1 = 8'($urandom_range(0, 255));
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        send_frame(d0, 1'b0, 1'b1);
        send_frame(d1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (start_q.size() != 2 || deser_cnt != 16) begin
            errors++; $display("FAIL b2b_starts: got %0d starts %0d deser want 2 16",
                               start_q.size(), deser_cnt);
        end
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", obs_q.size());
        end else begin
            while (exp_q.size() > 0) begin
                logic [2:0] got;
                logic [2:0] want;
                got = obs_q.pop_front();
                want = exp_q.pop_front();
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL b2b_code: got %b want %b", got, want);
                end
            end
            checks++;
            if (obs_cyc_q[1] - obs_cyc_q[0] != 80) begin
                errors++; $display("FAIL b2b_spacing: got %0d want 80", obs_cyc_q[1] - obs_cyc_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_sb();
        RX_IN = 1'b0;
        repeat (8 + 3 * 8 + 3) @(negedge clk);
        RX_IN = 1'b1;
        checks++;
        if (state_dbg !== 3'd2) begin
            errors++; $display("FAIL mid_in_data: got %0d want 2", state_dbg);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (state_dbg !== 3'd0 || {bus.edge_cnt_en, bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
            bus.par_chk_en, bus.stp_chk_en, framing_error, parity_error, data_valid} !== 9'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got state %0d en %b want 0 0",
                               state_dbg, bus.edge_cnt_en);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_sb();
        exp_q.push_back(3'b001);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || start_q.size() != 1) begin
            errors++; $display("FAIL post_reset_count: got %0d pulses %0d starts want 1 1",
                               obs_q.size(), start_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0] || obs_cyc_q[0] - start_q[0] != 80) begin
                errors++; $display("FAIL post_reset_frame: got %b at %0d want %b at 80",
                                   obs_q[0], obs_cyc_q[0] - start_q[0], exp_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_start_glitch();
        test_parity_error();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
